// File: rtl/miriscv_alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, the operator codes
// the ALU implements, the legality/comparison helpers and the FSM state type.
package miriscv_alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 7;

  // Operator codes implemented by miriscv_alu (upper bit always 0)
  localparam logic [OP_W_DEF-1:0] ALU_ADD = 7'h18;
  localparam logic [OP_W_DEF-1:0] ALU_SUB = 7'h19;
  localparam logic [OP_W_DEF-1:0] ALU_XOR = 7'h2F;
  localparam logic [OP_W_DEF-1:0] ALU_OR  = 7'h2E;
  localparam logic [OP_W_DEF-1:0] ALU_AND = 7'h15;
  localparam logic [OP_W_DEF-1:0] ALU_SRA = 7'h24;
  localparam logic [OP_W_DEF-1:0] ALU_SRL = 7'h25;
  localparam logic [OP_W_DEF-1:0] ALU_SLL = 7'h27;
  localparam logic [OP_W_DEF-1:0] ALU_LTS = 7'h00;
  localparam logic [OP_W_DEF-1:0] ALU_LTU = 7'h01;
  localparam logic [OP_W_DEF-1:0] ALU_GES = 7'h0A;
  localparam logic [OP_W_DEF-1:0] ALU_GEU = 7'h0B;
  localparam logic [OP_W_DEF-1:0] ALU_EQ  = 7'h0C;
  localparam logic [OP_W_DEF-1:0] ALU_NE  = 7'h0D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // True for the comparison operators, whose flag is meaningful
  function automatic logic op_is_cmp(input logic [OP_W_DEF-1:0] op);
    logic r;
    case (op)
      ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE: r = 1'b1;
      default:                                           r = 1'b0;
    endcase
    return r;
  endfunction

  // True for every code the ALU implements
  function automatic logic op_is_legal(input logic [OP_W_DEF-1:0] op);
    logic r;
    case (op)
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SRA, ALU_SRL, ALU_SLL:                         r = 1'b1;
      default:                                           r = op_is_cmp(op);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/miriscv_arb2.sv
// Two-way grant selection. A single valid requester always wins; a tie goes
// to requester 0, or, with MIRISCV_ALU_ARB_RR_EN defined, to the requester
// that was not granted last (pointer advances on every taken grant).
module miriscv_arb2 (
`ifdef MIRISCV_ALU_ARB_RR_EN
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       advance_i,
`endif
  input  logic [1:0] valid_i,
  output logic       any_o,
  output logic       sel_o
);

  assign any_o = |valid_i;

`ifdef MIRISCV_ALU_ARB_RR_EN
  // Starts at 1 so requester 0 wins the first tie after reset
  logic last_grant_q;

  // Remember who was granted whenever a grant is actually taken
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
    end else if (advance_i) begin
      last_grant_q <= sel_o;
    end
  end

  // Tie resolves away from the previous winner
  always_comb begin
    sel_o = valid_i[1];
    if (&valid_i) begin
      sel_o = ~last_grant_q;
    end
  end
`else
  // Fixed priority: requester 1 only when requester 0 is idle
  always_comb begin
    sel_o = valid_i[1] & ~valid_i[0];
  end
`endif

endmodule

// File: rtl/miriscv_alu_arbiter.sv
// Shares one combinational miriscv_alu between two requesters. A request is
// accepted in IDLE, its operands drive the ALU during EXEC, and the captured
// result is held in RESP until the owner accepts it. Unimplemented operator
// codes complete with a zero result and the error flag set.
// Optional: define MIRISCV_ALU_ARB_RR_EN for round-robin tie breaking.
module miriscv_alu_arbiter
  import miriscv_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic              rsp0_cmp_o,
  output logic              rsp0_err_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic              rsp1_cmp_o,
  output logic              rsp1_err_o,
  output logic [OP_W-1:0]   alu_operator_o,
  output logic [DATA_W-1:0] alu_operand_a_o,
  output logic [DATA_W-1:0] alu_operand_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_comparison_result_i,
  output logic              busy_o
);

  arb_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              owner_q;
  logic [DATA_W-1:0] result_q;
  logic              cmp_q;
  logic              err_q;

  logic sel;
  logic any_valid;
  logic accept;
  logic owner_rsp_ready;
  logic op_legal;

  miriscv_arb2 u_arb2 (
`ifdef MIRISCV_ALU_ARB_RR_EN
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .advance_i (accept),
`endif
    .valid_i   ({req1_valid_i, req0_valid_i}),
    .any_o     (any_valid),
    .sel_o     (sel)
  );

  assign owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;
  assign op_legal        = op_is_legal(op_q);

  // Next state and request handshakes; only IDLE ever offers ready
  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req0_ready_o = ~sel;
          req1_ready_o = sel;
          accept       = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted request on acceptance; capture ALU outputs after EXEC
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      cmp_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= sel ? req1_op_i : req0_op_i;
        a_q     <= sel ? req1_a_i  : req0_a_i;
        b_q     <= sel ? req1_b_i  : req0_b_i;
        owner_q <= sel;
      end
      if (state_q == EXEC) begin
        // Flag is only meaningful for comparisons; illegal codes yield zeros
        result_q <= op_legal ? alu_result_i : '0;
        cmp_q    <= op_legal & op_is_cmp(op_q) & alu_comparison_result_i;
        err_q    <= ~op_legal;
      end
    end
  end

  // The ALU always sees the latched operands, so it only moves on acceptance
  assign alu_operator_o  = op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;

  assign busy_o = (state_q != IDLE);

  // Responses are routed to the owner only
  assign rsp0_valid_o  = (state_q == RESP) & ~owner_q;
  assign rsp1_valid_o  = (state_q == RESP) &  owner_q;
  assign rsp0_result_o = owner_q ? '0 : result_q;
  assign rsp1_result_o = owner_q ? result_q : '0;
  assign rsp0_cmp_o    = ~owner_q & cmp_q;
  assign rsp1_cmp_o    =  owner_q & cmp_q;
  assign rsp0_err_o    = ~owner_q & err_q;
  assign rsp1_err_o    =  owner_q & err_q;

endmodule
